// File: rtl/regbank_pkg.sv
// Shared constants for the parametrised analog-control register bank.
// Control-register bit fields and the default address map used by the
// parent wrapper when slicing the shadow bank into analog controls.
package regbank_pkg;

  // Control register bit positions
  localparam int unsigned PWR_MODE  = 0;
  localparam int unsigned VUP       = 1;
  localparam int unsigned VDN       = 2;
  localparam int unsigned VCO_FIXED = 3;
  localparam int unsigned VSRC_SEL  = 4;

  // Default address map
  localparam int unsigned PGA     = 0;
  localparam int unsigned CTRL    = 1;
  localparam int unsigned VCO_SEL = 2;
  localparam int unsigned LOAD    = 5;
  localparam int unsigned COUNT   = 6;
  localparam int unsigned RAMP    = 7;

endpackage

// File: rtl/register_bank_param_if.sv
// Host port of the register bank, driven by the I2C slave front end.
//   master: reg_addr, data_in, wr_en, rd_en, auto_inc, ptr_load, commit (out)
//           data_out, rd_valid, rd_err, wr_err, ptr (in)
//   slave : the mirror image, used by register_bank_param.
interface register_bank_param_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();

  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              rd_en;
  logic              auto_inc;
  logic              ptr_load;
  logic              commit;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              rd_err;
  logic              wr_err;
  logic [ADDR_W-1:0] ptr;

  modport master (
    output reg_addr, data_in, wr_en, rd_en, auto_inc, ptr_load, commit,
    input  data_out, rd_valid, rd_err, wr_err, ptr
  );

  modport slave (
    input  reg_addr, data_in, wr_en, rd_en, auto_inc, ptr_load, commit,
    output data_out, rd_valid, rd_err, wr_err, ptr
  );

endinterface

// File: rtl/regbank_ptr.sv
// Burst pointer: loads from load_addr_i (priority) or post-increments,
// wrapping from NumRegs-1 back to 0.
//   clk_i, rst_ni : clock, async active-low reset (pointer resets to 0)
//   load_i        : load pointer from load_addr_i
//   inc_i         : advance pointer by one
//   ptr_o         : current pointer
module regbank_ptr #(
  parameter int unsigned NumRegs = 8,
  parameter int unsigned AddrW   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [AddrW-1:0] load_addr_i,
  input  logic             inc_i,
  output logic [AddrW-1:0] ptr_o
);

  logic [AddrW-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_addr_i;
    end else if (inc_i) begin
      // A pointer loaded beyond the bank simply counts on and wraps at 2**AddrW.
      ptr_d = (ptr_q == AddrW'(NumRegs - 1)) ? '0 : ptr_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/register_bank_param.sv
// Parametrised analog-control register bank with burst pointer, error
// pulses, write protection in low-power mode and a one-cycle shadow commit.
//   clk_i, rst_ni  : clock, async active-low reset
//   bus            : host port (slave side), see register_bank_param_if
//   pwr_mode_o     : live control register power-mode bit
//   live_regs_o    : flattened live bank, register i at [i*DATA_W +: DATA_W]
//   shadow_regs_o  : flattened shadow bank, same packing
//   shadow_valid_o : set by the first explicit commit
module register_bank_param
  import regbank_pkg::*;
#(
  parameter int unsigned       NUM_REGS    = 8,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       CTRL_ADDR   = CTRL,
  parameter logic [DATA_W-1:0] CTRL_RST    = DATA_W'(9),
  parameter bit                AUTO_COMMIT = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  register_bank_param_if.slave         bus,
  output logic                         pwr_mode_o,
  output logic [NUM_REGS*DATA_W-1:0]   live_regs_o,
  output logic [NUM_REGS*DATA_W-1:0]   shadow_regs_o,
  output logic                         shadow_valid_o
);

  function automatic logic [DATA_W-1:0] rst_val(int unsigned idx);
    return (idx == CTRL_ADDR) ? CTRL_RST : DATA_W'(2 * idx);
  endfunction

  logic [DATA_W-1:0] live_q   [NUM_REGS];
  logic [DATA_W-1:0] live_d   [NUM_REGS];
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic              shadow_valid_q, shadow_valid_d;

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_err_q, wr_err_q;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ea;
  logic              in_range;
  logic              ctrl_hit;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_data;

  regbank_ptr #(
    .NumRegs (NUM_REGS),
    .AddrW   (ADDR_W)
  ) u_ptr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (bus.ptr_load),
    .load_addr_i (bus.reg_addr),
    .inc_i       (bus.auto_inc & (bus.rd_en | bus.wr_en)),
    .ptr_o       (ptr)
  );

  assign ea       = bus.auto_inc ? ptr : bus.reg_addr;
  assign in_range = {1'b0, ea} < (ADDR_W + 1)'(NUM_REGS);
  assign ctrl_hit = (ea == ADDR_W'(CTRL_ADDR));
  // The control register stays writable so low-power mode can be left.
  assign wr_ok    = bus.wr_en & in_range & (ctrl_hit | live_q[CTRL_ADDR][PWR_MODE]);

  always_comb begin
    rd_data = '1;  // out-of-range reads return all ones
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (ea == ADDR_W'(i)) rd_data = live_q[i];
    end
  end

  always_comb begin
    live_d = live_q;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (wr_ok && (ea == ADDR_W'(i))) live_d[i] = bus.data_in;
    end
  end

  // Shadow copies the pre-write live bank, so a commit alongside a write
  // captures the old value.
  always_comb begin
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    if (bus.commit || (AUTO_COMMIT && !wr_ok)) begin
      shadow_d = live_q;
    end
    if (bus.commit) shadow_valid_d = 1'b1;
  end

  assign data_out_d = bus.rd_en ? rd_data : data_out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        live_q[i]   <= rst_val(i);
        shadow_q[i] <= '0;
      end
      shadow_valid_q <= 1'b0;
      data_out_q     <= '0;
      rd_valid_q     <= 1'b0;
      rd_err_q       <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      live_q         <= live_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      data_out_q     <= data_out_d;
      rd_valid_q     <= bus.rd_en;
      rd_err_q       <= bus.rd_en & ~in_range;
      wr_err_q       <= bus.wr_en & ~wr_ok;
    end
  end

  always_comb begin
    live_regs_o   = '0;
    shadow_regs_o = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      live_regs_o[i*DATA_W +: DATA_W]   = live_q[i];
      shadow_regs_o[i*DATA_W +: DATA_W] = shadow_q[i];
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.ptr        = ptr;
  assign pwr_mode_o     = live_q[CTRL_ADDR][PWR_MODE];
  assign shadow_valid_o = shadow_valid_q;

endmodule

// File: tb/tb_register_bank_param.sv
// Self-checking bench for register_bank_param with default parameters.
// A behavioural model tracks the bank; a negedge process compares every
// output to it, and directed steps pin hand-computed literal values.
module tb_register_bank_param;
  import regbank_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_bank_param_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic            pwr_mode;
  logic [N*DW-1:0] live_regs;
  logic [N*DW-1:0] shadow_regs;
  logic            shadow_valid;

  register_bank_param #(
    .NUM_REGS    (N),
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .CTRL_ADDR   (1),
    .CTRL_RST    (8'h09),
    .AUTO_COMMIT (1'b0)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus),
    .pwr_mode_o     (pwr_mode),
    .live_regs_o    (live_regs),
    .shadow_regs_o  (shadow_regs),
    .shadow_valid_o (shadow_valid)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_live   [N];
  logic [7:0] m_shadow [N];
  bit         m_sv, m_rv, m_re, m_we;
  logic [7:0] m_dout;
  int         m_ptr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_live[i]   = (i == 1) ? 8'h09 : 8'((2 * i) % 256);
      m_shadow[i] = 8'h00;
    end
    m_sv = 0; m_rv = 0; m_re = 0; m_we = 0; m_dout = 8'h00; m_ptr = 0;
  endtask

  task automatic model_step();
    int ea;
    bit inr, wacc;
    ea   = bus.auto_inc ? m_ptr : int'(bus.reg_addr);
    inr  = (ea < N);
    wacc = bus.wr_en && inr && (ea == 1 || m_live[1][0]);
    if (bus.commit) begin
      for (int i = 0; i < N; i++) m_shadow[i] = m_live[i];
      m_sv = 1;
    end
    m_rv = bus.rd_en;
    m_re = bus.rd_en && !inr;
    if (bus.rd_en) m_dout = inr ? m_live[ea] : 8'hFF;
    m_we = bus.wr_en && !wacc;
    if (wacc) m_live[ea] = bus.data_in;
    if (bus.ptr_load) m_ptr = int'(bus.reg_addr);
    else if (bus.auto_inc && (bus.rd_en || bus.wr_en))
      m_ptr = (m_ptr == N - 1) ? 0 : (m_ptr + 1) % 256;
  endtask

  function automatic logic [63:0] pack_live();
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_live[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_shadow();
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_shadow[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      logic [7:0] mp;
      mp = 8'(m_ptr);
      chk("cmp_data_out", bus.data_out, m_dout);
      chk("cmp_rd_valid", bus.rd_valid, m_rv);
      chk("cmp_rd_err", bus.rd_err, m_re);
      chk("cmp_wr_err", bus.wr_err, m_we);
      chk("cmp_ptr", bus.ptr, mp);
      chk("cmp_pwr_mode", pwr_mode, m_live[1][0]);
      chk("cmp_live", live_regs, pack_live());
      chk("cmp_shadow", shadow_regs, pack_shadow());
      chk("cmp_shadow_valid", shadow_valid, m_sv);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    bus.reg_addr = '0; bus.data_in = '0; bus.wr_en = 0; bus.rd_en = 0;
    bus.auto_inc = 0; bus.ptr_load = 0; bus.commit = 0;
  endtask

  task automatic acc(bit rd, bit wr, logic [7:0] addr, logic [7:0] d, bit ai, bit pl, bit cm);
    bus.rd_en = rd; bus.wr_en = wr; bus.reg_addr = addr; bus.data_in = d;
    bus.auto_inc = ai; bus.ptr_load = pl; bus.commit = cm;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wr(logic [7:0] addr, logic [7:0] d);
    acc(0, 1, addr, d, 0, 0, 0);
  endtask

  task automatic rd(logic [7:0] addr);
    acc(1, 0, addr, 8'h00, 0, 0, 0);
  endtask

  logic [7:0] exp_rst [N] = '{8'h00, 8'h09, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_live", live_regs, 64'h0E0C0A0806040900);
    chk("rst_shadow", shadow_regs, 64'h0);
    chk("rst_ptr", bus.ptr, 8'h00);
    chk("rst_data_out", bus.data_out, 8'h00);
    chk("rst_pulses", {bus.rd_valid, bus.rd_err, bus.wr_err}, 3'b000);
    chk("rst_shadow_valid", shadow_valid, 1'b0);
    chk("rst_pwr_mode", pwr_mode, 1'b1);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Read the reset map
    for (int i = 0; i < N; i++) begin
      rd(8'(i));
      chk("rd_reset_val", bus.data_out, exp_rst[i]);
      chk("rd_valid_pulse", bus.rd_valid, 1'b1);
    end
    @(posedge clk); #1;
    chk("rd_valid_drop", bus.rd_valid, 1'b0);
    chk("data_out_hold", bus.data_out, 8'h0E);

    // Same-cycle read and write of one address returns the old value
    acc(1, 1, 8'd3, 8'hC3, 0, 0, 0);
    chk("rw_same_old", bus.data_out, 8'h06);
    chk("rw_same_new", live_regs[3*8 +: 8], 8'hC3);

    // Low-power write protection
    wr(8'd1, 8'h00);
    chk("pwr_off", pwr_mode, 1'b0);
    wr(8'd2, 8'h55);
    chk("prot_wr_err", bus.wr_err, 1'b1);
    rd(8'd2);
    chk("prot_unchanged", bus.data_out, 8'h04);
    wr(8'd1, 8'h01);
    wr(8'd2, 8'h55);
    chk("unprot_wr_err", bus.wr_err, 1'b0);
    rd(8'd2);
    chk("unprot_written", bus.data_out, 8'h55);

    // Out-of-range access
    rd(8'd9);
    chk("oor_data", bus.data_out, 8'hFF);
    chk("oor_rd_err", bus.rd_err, 1'b1);
    wr(8'd9, 8'h77);
    chk("oor_wr_err", bus.wr_err, 1'b1);
    chk("oor_bank", live_regs, 64'h0E0C0A08C3550100);

    // Commit captures pre-write value, second commit captures the write
    acc(0, 1, 8'd0, 8'h33, 0, 0, 1);
    chk("commit_prewrite", shadow_regs[7:0], 8'h00);
    chk("commit_valid", shadow_valid, 1'b1);
    acc(0, 0, 8'd0, 8'h00, 0, 0, 1);
    chk("commit2_reg0", shadow_regs[7:0], 8'h33);
    chk("commit2_bank", shadow_regs, 64'h0E0C0A08C3550133);

    // Burst with wrap
    acc(0, 0, 8'd6, 8'h00, 0, 1, 0);
    chk("ptr_load", bus.ptr, 8'h06);
    acc(0, 1, 8'd0, 8'hA1, 1, 0, 0);
    acc(0, 1, 8'd0, 8'hA2, 1, 0, 0);
    acc(0, 1, 8'd0, 8'hA3, 1, 0, 0);
    chk("burst_r6", live_regs[6*8 +: 8], 8'hA1);
    chk("burst_r7", live_regs[7*8 +: 8], 8'hA2);
    chk("burst_r0", live_regs[7:0], 8'hA3);
    chk("burst_ptr", bus.ptr, 8'h01);

    // Simultaneous rd/wr advances by one; this write clears power mode
    acc(1, 1, 8'd0, 8'h5A, 1, 0, 0);
    chk("rdwr_ptr", bus.ptr, 8'h02);
    chk("rdwr_old", bus.data_out, 8'h01);
    chk("rdwr_pwr", pwr_mode, 1'b0);
    // Blocked auto_inc write still advances the pointer
    acc(0, 1, 8'd0, 8'hEE, 1, 0, 0);
    chk("blk_ptr", bus.ptr, 8'h03);
    chk("blk_err", bus.wr_err, 1'b1);
    chk("blk_reg2", live_regs[2*8 +: 8], 8'h55);
    wr(8'd1, 8'h01);

    // Reset mid-burst
    acc(0, 0, 8'd4, 8'h00, 0, 1, 0);
    acc(0, 1, 8'd0, 8'hBB, 1, 0, 0);
    chk("mid_written", live_regs[4*8 +: 8], 8'hBB);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_live", live_regs, 64'h0E0C0A0806040900);
    chk("mid_rst_ptr", bus.ptr, 8'h00);
    chk("mid_rst_shadow", shadow_regs, 64'h0);
    chk("mid_rst_sv", shadow_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc(1, 0, 8'd5, 8'h00, 1, 0, 0);
    chk("post_rst_rd", bus.data_out, 8'h00);
    chk("post_rst_ptr", bus.ptr, 8'h01);

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank_param.md
Name: register_bank_param

Overview:
- Parametrised successor to the fixed 8x8 analog-control register map.
- Holds NUM_REGS registers of DATA_W bits behind a single-clock host port, which is driven by the I2C slave front end.
- Adds a burst auto-increment pointer, error flags, and a commit strobe that copies the live registers into a shadow bank in one cycle. The analog controls (PGA, VCO, ramp, load select) are taken from the shadow bank.
- Write protection in low-power mode is kept from the previous generation, with the control-register address now a parameter.

Parameters:
- NUM_REGS, 8, number of registers (2..256).
- DATA_W, 8, register width in bits.
- ADDR_W, 8, host address width; must satisfy 2**ADDR_W >= NUM_REGS.
- CTRL_ADDR, 1, address of the power/control register; it is always writable.
- CTRL_RST, 8'h09, reset value of the control register (bit0 = Pwr_mode = 1, bit3 = Vco_fixed_select = 1).
- AUTO_COMMIT, 0, if 1 the shadow bank reloads every cycle while no write is accepted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- reg_addr  in  ADDR_W  access address, used when auto_inc = 0
- data_in  in  DATA_W  write data
- wr_en  in  1  one-cycle write request
- rd_en  in  1  one-cycle read request
- auto_inc  in  1  1 = use the internal pointer and post-increment it
- ptr_load  in  1  load the pointer from reg_addr
- commit  in  1  one-cycle pulse: shadow <= live
- data_out  out  DATA_W  read data, registered
- rd_valid  out  1  pulses the cycle after an accepted rd_en
- rd_err  out  1  pulses with rd_valid when the address was out of range
- wr_err  out  1  pulses the cycle after a blocked or out-of-range write
- ptr  out  ADDR_W  current burst pointer
- pwr_mode  out  1  live control register bit0
- live_regs  out  NUM_REGS*DATA_W  flattened live bank; register i is at bits [i*DATA_W +: DATA_W]
- shadow_regs  out  NUM_REGS*DATA_W  flattened shadow bank, same packing
- shadow_valid  out  1  set on the first commit, cleared by reset

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is asynchronous and active-low.
  - Reset values: live[i] = (2*i) mod 2**DATA_W for every i except CTRL_ADDR; live[CTRL_ADDR] = CTRL_RST.
  - Also at reset: shadow all 0, data_out 0, ptr 0, and all pulse outputs 0.
- Effective address:
  - ea = ptr when auto_inc = 1, otherwise reg_addr.
  - An address is in range when ea < NUM_REGS.
- Writes (wr_en = 1):
  - ea == CTRL_ADDR: always accepted.
  - Other in-range ea: accepted only when live[CTRL_ADDR][0] = 1.
  - Blocked or out-of-range writes leave the bank unchanged and give wr_err = 1 in the next cycle.
  - An accepted write updates live at the clock edge.
- Reads (rd_en = 1):
  - Next cycle: data_out = live[ea] and rd_valid = 1.
  - If ea is out of range: data_out = all ones and rd_err = 1.
  - data_out holds its value until the next read.
- Read and write on the same ea in the same cycle: the read returns the pre-write value.
- Pointer:
  - ptr_load has priority: ptr <= reg_addr.
  - Otherwise, an access with auto_inc = 1 (rd_en or wr_en) advances ptr by 1, wrapping from NUM_REGS-1 to 0.
  - Simultaneous rd_en and wr_en advance ptr by 1, not 2.
  - Blocked writes still advance ptr.
- Commit:
  - commit copies all live registers into shadow in one cycle and sets shadow_valid.
  - commit in the same cycle as a write captures the pre-write live value.
- AUTO_COMMIT = 1: shadow follows live with one cycle of latency, except in cycles where a write is accepted.
- pwr_mode is combinational from live[CTRL_ADDR][0].
- Reset asserted mid-burst restores all reset values immediately; the next access after reset release starts at ptr = 0.
- Implementation notes:
  - Host accesses are handled by a small sequential decode, with no multi-cycle FSM. The state is the pointer, the pulse registers and the banks.
  - No initial blocks and no free-running internal clock.

Decomposition:
- Package regbank_pkg holds:
  - the field constants for the control register bits: PWR_MODE = 0, VUP = 1, VDN = 2, VCO_FIXED = 3, VSRC_SEL = 4;
  - the default address map constants: PGA = 0, CTRL = 1, VCO_SEL = 2, LOAD = 5, COUNT = 6, RAMP = 7.
- One natural sub-module, regbank_ptr: the wrapping burst pointer with load and increment.
- Field slicing into the analog controls (VCVGA, PD, VCO_SEL, and so on) stays in the parent wrapper, not in this block.

Test Plan:
- Reset, then read addresses 0..7 with the default parameters -> data_out = 00, 02, 04, 06, 08, 0A, 0C, 0E, except address 1 = 09; rd_valid pulses once per read, one cycle after each rd_en.
- Write 8'h00 to address 1, then write 8'h55 to address 2 -> wr_err pulses; address 2 reads 04. Write 8'h01 to address 1, then write 8'h55 to address 2 -> address 2 reads 55.
- Read address 9 -> data_out = FF and rd_err = 1; write address 9 -> wr_err = 1 and the bank is unchanged.
- ptr_load with address 6, then three auto_inc writes A1, A2, A3 -> registers 6 = A1, 7 = A2, 0 = A3; ptr ends at 1.
- Write 8'h33 to address 0 and commit in the same cycle -> shadow[0] = 00; a second commit -> shadow[0] = 33 and shadow_valid = 1.
- Assert reset in the middle of a burst after one write -> all registers, including the written one, return to reset values; ptr = 0; shadow is all 0.
